// File: rtl/decoded_micro_op_picker_pkg.sv
// rtl/decoded_micro_op_picker_pkg.sv - micro-op types and group sizing for the decoded micro-op picker
package decoded_micro_op_picker_pkg;

   localparam int DECODE_WIDTH = 2;
   localparam int MICRO_OP_MAX_NUM = 3;
   localparam int ALL_DECODED_MICRO_OP_WIDTH = MICRO_OP_MAX_NUM * DECODE_WIDTH;
   // Top bit index of a count that can reach ALL_DECODED_MICRO_OP_WIDTH inclusive.
   localparam int ALL_DECODED_MICRO_OP_WIDTH_BIT_SIZE = $clog2(ALL_DECODED_MICRO_OP_WIDTH + 1) - 1;
   localparam int PICK_INDEX_WIDTH = $clog2(ALL_DECODED_MICRO_OP_WIDTH);

   typedef struct packed {
      logic        valid;
      logic [1:0]  mid;
      logic        split;
      logic        last;
      logic [7:0]  opcode;
      logic [15:0] pc;
   } OpInfo;

   typedef OpInfo [ALL_DECODED_MICRO_OP_WIDTH-1:0] AllDecodedMicroOpPath;
   typedef OpInfo [DECODE_WIDTH-1:0] DecodedMicroOpPath;
   typedef logic [ALL_DECODED_MICRO_OP_WIDTH_BIT_SIZE:0] AllDecodedMicroOpCount;
   typedef logic [PICK_INDEX_WIDTH-1:0] PickIndex;

endpackage

// File: rtl/decoded_micro_op_picker_micro_op_pick_encoder.sv
// rtl/decoded_micro_op_picker_micro_op_pick_encoder.sv - selects the lowest DECODE_WIDTH set bits of a mask
module micro_op_pick_encoder
   import decoded_micro_op_picker_pkg::*;
(
   input  logic [ALL_DECODED_MICRO_OP_WIDTH-1:0]        mask,
   output logic [DECODE_WIDTH-1:0][PICK_INDEX_WIDTH-1:0] lane_idx,
   output logic [DECODE_WIDTH-1:0]                      lane_valid,
   output logic [ALL_DECODED_MICRO_OP_WIDTH-1:0]        cleared_mask
);

   logic [ALL_DECODED_MICRO_OP_WIDTH-1:0] rest;

   // Each lane takes the lowest bit still set, then removes it for the next lane.
   always_comb begin
      rest = mask;
      lane_idx = '0;
      lane_valid = '0;
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         for (int k = ALL_DECODED_MICRO_OP_WIDTH - 1; k >= 0; k--) begin
            if (rest[k]) begin
               lane_valid[j] = 1'b1;
               lane_idx[j] = PICK_INDEX_WIDTH'(k);
            end
         end
         if (lane_valid[j]) begin
            rest[lane_idx[j]] = 1'b0;
         end
      end
      cleared_mask = rest;
   end

endmodule

// File: rtl/decoded_micro_op_picker.sv
// rtl/decoded_micro_op_picker.sv - buffers one decoded group and issues it DECODE_WIDTH micro-ops per cycle
module decoded_micro_op_picker
   import decoded_micro_op_picker_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  inValid,
   output logic                  inReady,
   input  AllDecodedMicroOpPath  inOps,
   output logic [DECODE_WIDTH-1:0] outValid,
   output DecodedMicroOpPath     outOps,
   input  logic                  outReady,
   output AllDecodedMicroOpCount remaining
);

   logic [ALL_DECODED_MICRO_OP_WIDTH-1:0]        live;
   logic [ALL_DECODED_MICRO_OP_WIDTH-1:0]        cleared;
   logic [ALL_DECODED_MICRO_OP_WIDTH-1:0]        in_live;
   logic [DECODE_WIDTH-1:0][PICK_INDEX_WIDTH-1:0] lane_idx;
   logic [DECODE_WIDTH-1:0]                      lane_valid;
   AllDecodedMicroOpPath                         op_buf;
   logic                                         load;
   logic                                         consume;

   micro_op_pick_encoder u_pick (
      .mask         (live),
      .lane_idx     (lane_idx),
      .lane_valid   (lane_valid),
      .cleared_mask (cleared)
   );

   always_comb begin
      in_live = '0;
      for (int k = 0; k < ALL_DECODED_MICRO_OP_WIDTH; k++) begin
         in_live[k] = inOps[k].valid;
      end
   end

   assign remaining = AllDecodedMicroOpCount'($countones(live));
   // A new group may be taken while the current one finishes on the same edge.
   assign inReady = (live == '0) ||
                    (outReady && (remaining <= AllDecodedMicroOpCount'(DECODE_WIDTH)));
   assign load = inValid && inReady && !flush && !rst;
   assign consume = outReady && lane_valid[0];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         live <= '0;
      end else if (load) begin
         live <= in_live;
      end else if (consume) begin
         live <= cleared;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         op_buf <= inOps;
      end
   end

   always_comb begin
      outValid = lane_valid;
      outOps = '0;
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         if (lane_valid[j]) begin
            outOps[j] = op_buf[lane_idx[j]];
         end
      end
   end

endmodule

// File: tb/tb_decoded_micro_op_picker.sv
// tb/tb_decoded_micro_op_picker.sv - directed and randomized checks against a queue-based model
module tb_decoded_micro_op_picker;
   import decoded_micro_op_picker_pkg::*;

   localparam int ALL = ALL_DECODED_MICRO_OP_WIDTH;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    flush;
   logic                    inValid;
   logic                    inReady;
   AllDecodedMicroOpPath    inOps;
   logic [DECODE_WIDTH-1:0] outValid;
   DecodedMicroOpPath       outOps;
   logic                    outReady;
   AllDecodedMicroOpCount   remaining;

   int checks = 0;
   int failures = 0;

   // Model: ordered list of buffered entry indices still waiting to issue.
   int    q[$];
   OpInfo m_buf[ALL];

   decoded_micro_op_picker dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .inValid   (inValid),
      .inReady   (inReady),
      .inOps     (inOps),
      .outValid  (outValid),
      .outOps    (outOps),
      .outReady  (outReady),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic make_group(input logic [ALL-1:0] m);
      for (int k = 0; k < ALL; k++) begin
         inOps[k].valid  = m[k];
         inOps[k].mid    = 2'(k % MICRO_OP_MAX_NUM);
         inOps[k].split  = 1'($urandom);
         inOps[k].last   = (k % MICRO_OP_MAX_NUM) == MICRO_OP_MAX_NUM - 1;
         inOps[k].opcode = 8'($urandom);
         inOps[k].pc     = 16'($urandom);
      end
   endtask

   // Called at posedge+1 with inputs driven; checks mid-cycle, advances model across the edge.
   task automatic step();
      int n;
      bit exp_rdy;
      #4;
      n = (q.size() < DECODE_WIDTH) ? q.size() : DECODE_WIDTH;
      exp_rdy = (q.size() == 0) || (outReady && q.size() <= DECODE_WIDTH);
      chk("remaining", 64'(remaining), 64'(q.size()));
      chk("inReady", 64'(inReady), 64'(exp_rdy));
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         chk("outValid", 64'(outValid[j]), 64'(j < n));
         if (j < n) chk("outOps", 64'(outOps[j]), 64'(m_buf[q[j]]));
         else chk("outOps_idle", 64'(outOps[j]), 64'(0));
      end
      if (rst || flush) begin
         q.delete();
      end else begin
         if (outReady) repeat (n) void'(q.pop_front());
         if (inValid && exp_rdy) begin
            q.delete();
            for (int k = 0; k < ALL; k++) begin
               m_buf[k] = inOps[k];
               if (inOps[k].valid) q.push_back(k);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_group(input logic [ALL-1:0] m);
      make_group(m);
      inValid = 1'b1;
      step();
      inValid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      make_group('0);
      @(posedge clk); #1;
      step();
      rst = 1'b0;
      chk("reset_outValid", 64'(outValid), 64'(0));
      chk("reset_inReady", 64'(inReady), 64'(1));
      chk("reset_remaining", 64'(remaining), 64'(0));

      // Straight group of three.
      load_group(6'b000111);
      step();
      chk("tp1_outValid", 64'(outValid), 64'(2'b01));
      chk("tp1_inReady", 64'(inReady), 64'(1));
      step();

      // Holes.
      load_group(6'b101001);
      chk("holes_rem3", 64'(remaining), 64'(3));
      step();
      chk("holes_rem1", 64'(remaining), 64'(1));
      step();
      chk("holes_rem0", 64'(remaining), 64'(0));

      // Back-pressure.
      load_group(6'b111111);
      outReady = 1'b0;
      repeat (4) step();
      chk("bp_remaining", 64'(remaining), 64'(6));
      chk("bp_inReady", 64'(inReady), 64'(0));
      outReady = 1'b1;
      repeat (3) step();

      // Back-to-back groups with no bubble.
      make_group(6'b000011);
      inValid = 1'b1;
      step();
      make_group(6'b000001);
      step();
      inValid = 1'b0;
      chk("b2b_outValid", 64'(outValid), 64'(2'b01));
      step();

      // Flush mid-drain with a group presented.
      load_group(6'b111111);
      step();
      flush = 1'b1;
      make_group(6'b111111);
      inValid = 1'b1;
      step();
      flush = 1'b0; inValid = 1'b0;
      chk("flush_outValid", 64'(outValid), 64'(0));
      chk("flush_remaining", 64'(remaining), 64'(0));
      step();

      // Reset mid-drain with a group presented.
      load_group(6'b111111);
      step();
      rst = 1'b1;
      make_group(6'b010101);
      inValid = 1'b1;
      step();
      rst = 1'b0; inValid = 1'b0;
      chk("rst_outValid", 64'(outValid), 64'(0));
      chk("rst_inReady", 64'(inReady), 64'(1));
      step();

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         make_group(ALL'($urandom));
         inValid  = ($urandom_range(0, 9) < 7);
         outReady = ($urandom_range(0, 9) < 7);
         flush    = ($urandom_range(0, 19) == 0);
         rst      = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
